// File: rtl/fir_pkg.sv
// fir_pkg: shared helpers and defaults for the parametrised FIR filter.
//   clog2_safe  - ceil(log2(n)), never less than 1 (usable as a port width).
//   acc_width   - full-precision accumulator width for a TAPS-term dot product.
//   FIR_DEF_*   - default parameter values used by fir_filter_param.
package fir_pkg;

    localparam int FIR_DEF_TAPS   = 4;
    localparam int FIR_DEF_COEF_W = 8;
    localparam int FIR_DEF_SHIFT  = 0;

    function automatic int clog2_safe(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Each product needs data_w+coef_w bits; summing taps terms adds clog2(taps).
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_tap_line.sv
// fir_tap_line: DEPTH-deep enable-shift register holding the past samples
// x[n-1] .. x[n-DEPTH] of the FIR.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears every tap
//   en_i     - shift in d_i this cycle
//   flush_i  - synchronous clear of every tap (wins over en_i)
//   d_i      - sample entering tap 0
//   q_o      - all taps, q_o[0] is the most recent sample
module fir_tap_line #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic                      flush_i,
    input  logic [W-1:0]              d_i,
    output logic [DEPTH-1:0][W-1:0]   q_o
);

    logic [DEPTH-1:0][W-1:0] line_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
        end else if (flush_i) begin
            line_q <= '0;
        end else if (en_i) begin
            line_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                line_q[k] <= line_q[k-1];
            end
        end
    end

    assign q_o = line_q;

endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: unsigned direct-form FIR, two-stage pipeline.
//   Stage 1 registers the TAPS products, stage 2 registers the scaled sum.
//   Coefficients are written into a shadow bank and copied to the active
//   bank on coef_commit; the datapath only ever reads the active bank.
// Optional feature macro: FIR_ROUND_SAT_EN (round half-up before the right
//   shift and saturate to OUT_W bits, reporting saturation on sat_flag).
//   Without it the output is a plain truncating bit slice and sat_flag is 0.
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   in_valid, data_in        - input sample and its qualifier
//   flush                    - synchronous clear of delay line and pipeline valids
//   coef_we/addr/data        - shadow coefficient write
//   coef_commit              - copy shadow bank (incl. same-cycle write) to active
//   out_valid, data_out      - one-cycle result pulse, data held between pulses
//   sat_flag                 - last result was saturated
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int TAPS   = FIR_DEF_TAPS,
    parameter int DATA_W = 32,
    parameter int COEF_W = FIR_DEF_COEF_W,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = FIR_DEF_SHIFT,
    localparam int CW    = clog2_safe(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush,
    input  logic              coef_we,
    input  logic [CW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_commit,
    output logic              out_valid,
    output logic [OUT_W-1:0]  data_out,
    output logic              sat_flag
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    // Wide enough that the shift never loses bits we still need to inspect.
    localparam int EXT_W = ACC_W + 1 + OUT_W;

`ifdef FIR_ROUND_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [ACC_W:0] ONE = (ACC_W+1)'(1);
    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic [ACC_W:0] RND = (ONE << SHIFT) >> 1;

    logic                          accept;
    logic [TAPS-2:0][DATA_W-1:0]   x;
    logic [TAPS-1:0][COEF_W-1:0]   shadow_q, shadow_d, active_q;
    logic [TAPS-1:0][ACC_W-1:0]    prod_d, prod_q;
    logic                          v1_q;
    logic [ACC_W-1:0]              acc;
    logic [ACC_W:0]                scale_src;
    logic [EXT_W-1:0]              ext;
    logic                          sat_d;
    logic [OUT_W-1:0]              data_d;
    logic                          out_valid_q, sat_q;
    logic [OUT_W-1:0]              data_out_q;

    assign accept = in_valid && !flush;

    fir_tap_line #(
        .DEPTH (TAPS-1),
        .W     (DATA_W)
    ) u_tap_line (
        .clk     (clk),
        .reset   (reset),
        .en_i    (accept),
        .flush_i (flush),
        .d_i     (data_in),
        .q_o     (x)
    );

    // Shadow next state; commit copies this so a same-cycle write is included.
    always_comb begin
        shadow_d = shadow_q;
        if (coef_we && (int'(coef_addr) < TAPS)) begin
            shadow_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (coef_commit) begin
                active_q <= shadow_d;
            end
        end
    end

    // Products use the active bank as it stands before any same-cycle commit.
    always_comb begin
        prod_d    = '0;
        prod_d[0] = ACC_W'(data_in) * ACC_W'(active_q[0]);
        for (int k = 1; k < TAPS; k++) begin
            prod_d[k] = ACC_W'(x[k-1]) * ACC_W'(active_q[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                prod_q <= prod_d;
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + prod_q[k];
        end
    end

    assign scale_src = {1'b0, acc} + (SAT_EN ? RND : '0);
    assign ext       = EXT_W'(scale_src) >> SHIFT;
    assign sat_d     = SAT_EN && (|(ext >> OUT_W));
    assign data_d    = sat_d ? {OUT_W{1'b1}} : ext[OUT_W-1:0];

    // A flush drops whatever sits in stage 1 but keeps the last result visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= v1_q && !flush;
            if (v1_q && !flush) begin
                data_out_q <= data_d;
                sat_q      <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param. A second instance with OUT_W=8,
// SHIFT=4 shares the stimulus and is checked for the scaling cases.
module tb_fir_filter_param;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  data_in;
    logic        flush;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_commit;
    logic        out_valid;
    logic [15:0] data_out;
    logic        sat_flag;
    logic        out_valid2;
    logic [7:0]  data_out2;
    logic        sat_flag2;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef FIR_ROUND_SAT_EN
    localparam logic [31:0] EXP2_24      = 2;
    localparam logic [31:0] EXP2_FIRST   = 255;
    localparam logic [31:0] EXP2_FIRST_S = 1;
    localparam logic [31:0] EXP2_FULL    = 255;
    localparam logic [31:0] EXP2_FULL_S  = 1;
    localparam logic [31:0] EXP1_FULL    = 65535;
    localparam logic [31:0] EXP1_FULL_S  = 1;
`else
    localparam logic [31:0] EXP2_24      = 1;
    localparam logic [31:0] EXP2_FIRST   = 224;
    localparam logic [31:0] EXP2_FIRST_S = 0;
    localparam logic [31:0] EXP2_FULL    = 128;
    localparam logic [31:0] EXP2_FULL_S  = 0;
    localparam logic [31:0] EXP1_FULL    = 63492;
    localparam logic [31:0] EXP1_FULL_S  = 0;
`endif

    fir_filter_param #(
        .TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_commit(coef_commit),
        .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
    );

    fir_filter_param #(
        .TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(8), .SHIFT(4)
    ) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_commit(coef_commit),
        .out_valid(out_valid2), .data_out(data_out2), .sat_flag(sat_flag2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: everything is driven and observed 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 8'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic wr_all(input int c0, input int c1, input int c2, input int c3);
        wr(0, c0);
        wr(1, c1);
        wr(2, c2);
        wr(3, c3);
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Accept one sample, then advance to the edge where its result appears.
    task automatic send(input int val);
        in_valid = 1'b1;
        data_in  = 8'(val);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        data_in     = '0;
        flush       = 1'b0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        coef_commit = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_sat", 32'(sat_flag), 0);
        check("rst_data2", 32'(data_out2), 0);
        reset = 1'b1;
        tick();

        // Moving average: coefficients 32, five back-to-back samples of 100
        wr_all(32, 32, 32, 32);
        commit();
        in_valid = 1'b1;
        data_in  = 8'd100;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) in_valid = 1'b0;
            tick();
            check($sformatf("mavg_valid_%0d", k), 32'(out_valid), 1);
            check($sformatf("mavg_data_%0d", k), 32'(data_out), 32'(3200 * ((k < 4) ? k : 4)));
        end
        tick();
        check("mavg_idle_valid", 32'(out_valid), 0);
        check("mavg_hold_data", 32'(data_out), 12800);

        // Flush: in-flight sample and the colliding sample are both dropped
        in_valid = 1'b1;
        data_in  = 8'd100;
        tick();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_hold_data", 32'(data_out), 12800);
        tick();
        check("flush_dropped", 32'(out_valid), 0);
        send(100);
        check("flush_next_valid", 32'(out_valid), 1);
        check("flush_next_data", 32'(data_out), 3200);

        // Gapped input with coefficients {1,2,3,4}
        do_flush();
        wr_all(1, 2, 3, 4);
        commit();
        send(10);
        check("gap_v1", 32'(out_valid), 1);
        check("gap_d1", 32'(data_out), 10);
        tick();
        check("gap_idle1", 32'(out_valid), 0);
        tick();
        check("gap_idle2", 32'(out_valid), 0);
        send(20);
        check("gap_v2", 32'(out_valid), 1);
        check("gap_d2", 32'(data_out), 40);
        tick();
        check("gap_idle3", 32'(out_valid), 0);
        send(30);
        check("gap_v3", 32'(out_valid), 1);
        check("gap_d3", 32'(data_out), 100);
        tick();
        check("gap_idle4", 32'(out_valid), 0);

        // Commit collision: sample in the commit cycle uses the old bank
        wr_all(1, 1, 1, 1);
        commit();
        do_flush();
        wr_all(2, 2, 2, 2);
        in_valid    = 1'b1;
        data_in     = 8'd5;
        coef_commit = 1'b1;
        tick();
        in_valid    = 1'b0;
        coef_commit = 1'b0;
        tick();
        check("collide_old", 32'(data_out), 5);
        send(5);
        check("collide_new", 32'(data_out), 20);

        // Write bypass: coefficient 3 written in the commit cycle
        wr(0, 3);
        wr(1, 3);
        wr(2, 3);
        coef_we     = 1'b1;
        coef_addr   = 2'd3;
        coef_data   = 8'd3;
        coef_commit = 1'b1;
        tick();
        coef_we     = 1'b0;
        coef_commit = 1'b0;
        do_flush();
        in_valid = 1'b1;
        data_in  = 8'd1;
        tick();
        data_in = 8'd0;
        tick();
        check("bypass_tap0", 32'(data_out), 3);
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("bypass_tap3", 32'(data_out), 3);

        // Scaling: acc=24, then all-255 saturation/truncation
        wr_all(1, 0, 0, 0);
        commit();
        do_flush();
        send(24);
        check("scale24_data1", 32'(data_out), 24);
        check("scale24_valid2", 32'(out_valid2), 1);
        check("scale24_data2", 32'(data_out2), EXP2_24);
        wr_all(255, 255, 255, 255);
        commit();
        do_flush();
        in_valid = 1'b1;
        data_in  = 8'd255;
        tick();
        tick();
        check("full_first_data2", 32'(data_out2), EXP2_FIRST);
        check("full_first_sat2", 32'(sat_flag2), EXP2_FIRST_S);
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("full_data1", 32'(data_out), EXP1_FULL);
        check("full_sat1", 32'(sat_flag), EXP1_FULL_S);
        check("full_data2", 32'(data_out2), EXP2_FULL);
        check("full_sat2", 32'(sat_flag2), EXP2_FULL_S);
        tick();
        check("full_idle_valid2", 32'(out_valid2), 0);
        check("full_hold_sat2", 32'(sat_flag2), EXP2_FULL_S);

        // Asynchronous reset between edges with a sample in flight
        in_valid = 1'b1;
        data_in  = 8'd255;
        tick();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_data", 32'(data_out), 0);
        check("arst_sat", 32'(sat_flag), 0);
        check("arst_data2", 32'(data_out2), 0);
        check("arst_sat2", 32'(sat_flag2), 0);
        tick();
        check("arst_no_out", 32'(out_valid), 0);
        reset = 1'b1;
        tick();
        send(200);
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_data", 32'(data_out), 0);
        check("post_rst_data2", 32'(data_out2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
